// File: rtl/edge_evt_pkg.sv
// Shared types and helpers for the edge-event scheduler.
package edge_evt_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } fsm_state_t;

  // Width of an input index; a single-input build still needs one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_evt_chan.sv
// One requester lane: edge detect, saturating pending-event counter and
// sticky overflow flag.
module edge_evt_chan #(
  parameter int RISING_EDGE = 1,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic lvl,
  input  logic dec,
  input  logic ovf_clr,
  output logic pend_nz,
  output logic ovf
);

  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  logic             prev;
  logic [CNT_W-1:0] pend;
  logic             edge_det;
  logic             inc;
  logic             sat;
  logic             ovf_set;

  assign edge_det = (RISING_EDGE != 0) ? (lvl & ~prev) : (~lvl & prev);
  assign inc      = edge_det & en;
  assign sat      = (pend == PEND_MAX);
  // A decrement in the same cycle frees the slot, so a saturated edge is kept.
  assign ovf_set  = inc & sat & ~dec;
  assign pend_nz  = |pend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev <= 1'b0;
      pend <= '0;
      ovf  <= 1'b0;
    end else begin
      prev <= lvl;
      if (inc && !dec && !sat)
        pend <= pend + CNT_W'(1);
      else if (dec && !inc)
        pend <= pend - CNT_W'(1);
      ovf <= ovf_set | (ovf & ~ovf_clr);
    end
  end

endmodule

// File: rtl/edge_evt_sched.sv
// Edge-event scheduler: per-input pending counters drained one event at a
// time through a valid/ready port in round-robin order.
module edge_evt_sched
  import edge_evt_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int RISING_EDGE = 1,
  parameter  int CNT_W       = 4,
  localparam int ID_W        = id_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] lvl_i,
  output logic               evt_valid,
  output logic [ID_W-1:0]    evt_id,
  input  logic               evt_ready,
  output logic [NUM_REQ-1:0] ovf,
  input  logic               ovf_clr
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  fsm_state_t         state, state_nxt;
  logic [ID_W-1:0]    rr_ptr, rr_nxt;
  logic [ID_W-1:0]    evt_id_nxt;
  logic [ID_W-1:0]    pick_id;
  logic               pick_vld;
  logic [NUM_REQ-1:0] pend_nz;
  logic [NUM_REQ-1:0] dec;
  int                 rr_idx;

  for (genvar n = 0; n < NUM_REQ; n++) begin : g_chan
    edge_evt_chan #(
      .RISING_EDGE(RISING_EDGE),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .lvl    (lvl_i[n]),
      .dec    (dec[n]),
      .ovf_clr(ovf_clr),
      .pend_nz(pend_nz[n]),
      .ovf    (ovf[n])
    );
  end

  // Scan offsets high to low so the smallest offset from rr_ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    rr_idx   = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      rr_idx = int'(rr_ptr) + i;
      if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
      if (pend_nz[ID_W'(rr_idx)]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(rr_idx);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    evt_id_nxt = evt_id;
    rr_nxt     = rr_ptr;
    dec        = '0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          evt_id_nxt = pick_id;
          state_nxt  = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          dec[evt_id] = 1'b1;
          rr_nxt      = (evt_id == LAST_ID) ? '0 : evt_id + ID_W'(1);
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      evt_id <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
      evt_id <= evt_id_nxt;
    end
  end

  assign evt_valid = (state == OFFER);

endmodule

// File: tb/tb_edge_evt_sched.sv
// Directed bench for edge_evt_sched with a cycle-level reference model.
module tb_edge_evt_sched;

  localparam int N    = 4;
  localparam int CW   = 2;
  localparam int IDW  = 2;
  localparam int MAXP = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b1;
  logic [N-1:0]   lvl_i = '0;
  logic           evt_valid;
  logic [IDW-1:0] evt_id;
  logic           evt_ready = 1'b0;
  logic [N-1:0]   ovf;
  logic           ovf_clr = 1'b0;

  always #5 clk = ~clk;

  edge_evt_sched #(.NUM_REQ(N), .RISING_EDGE(1), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .lvl_i    (lvl_i),
    .evt_valid(evt_valid),
    .evt_id   (evt_id),
    .evt_ready(evt_ready),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: counts of pending events, who is being offered, and
  // where the next round-robin search starts.
  int     m_pend[N];
  bit     m_prev[N];
  bit [N-1:0] m_ovf = '0;
  bit     m_off = 1'b0;
  int     m_id = 0;
  int     m_rr = 0;
  bit     chk_en = 1'b0;

  task automatic model_step();
    bit hs;
    hs = m_off && evt_ready;
    if (!m_off) begin
      for (int k = 0; k < N; k++) begin
        int j = (m_rr + k) % N;
        if (m_pend[j] > 0) begin
          m_id  = j;
          m_off = 1'b1;
          break;
        end
      end
    end else if (evt_ready) begin
      m_rr  = (m_id + 1) % N;
      m_off = 1'b0;
    end
    for (int n = 0; n < N; n++) begin
      bit inc = lvl_i[n] && !m_prev[n] && en;
      bit dcr = hs && (m_id == n);
      bit oset = 1'b0;
      if (inc && !dcr) begin
        if (m_pend[n] == MAXP) oset = 1'b1;
        else m_pend[n]++;
      end else if (dcr && !inc) begin
        m_pend[n]--;
      end
      if (oset) m_ovf[n] = 1'b1;
      else if (ovf_clr) m_ovf[n] = 1'b0;
      m_prev[n] = lvl_i[n];
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int n = 0; n < N; n++) begin
        m_pend[n] = 0;
        m_prev[n] = 1'b0;
      end
      m_ovf  = '0;
      m_off  = 1'b0;
      m_id   = 0;
      m_rr   = 0;
      chk_en = 1'b1;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_valid", evt_valid, m_off);
      if (m_off) check("model_id", evt_id, m_id);
      check("model_ovf", ovf, m_ovf);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_hs(input int exp_id, input string name);
    for (int i = 0; i < 40; i++) begin
      if (evt_valid && evt_ready) begin
        check(name, evt_id, exp_id);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    n_chk++;
    n_fail++;
    $display("FAIL %s: no handshake within 40 cycles, expected id %0d", name, exp_id);
  endtask

  task automatic quiet(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      check(name, evt_valid, 0);
      cyc(1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cyc(2);
    rst_n = 1'b1;
    check("rst_valid", evt_valid, 0);
    check("rst_ovf", ovf, 0);
    cyc(3);

    // Single edge: visible two cycles later, gone the cycle after handshake.
    evt_ready = 1'b1;
    lvl_i = 4'b0100;
    cyc(1);
    check("single_t1_valid", evt_valid, 0);
    cyc(1);
    check("single_t2_valid", evt_valid, 1);
    check("single_t2_id", evt_id, 2);
    cyc(1);
    check("single_t3_valid", evt_valid, 0);
    lvl_i = '0;
    quiet(6, "single_quiet");

    // Round-robin from a fresh reset.
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    lvl_i = 4'b1011;
    wait_hs(0, "rr_a0");
    wait_hs(1, "rr_a1");
    wait_hs(3, "rr_a3");
    lvl_i = '0;
    cyc(2);
    lvl_i = 4'b1001;
    wait_hs(0, "rr_b0");
    wait_hs(3, "rr_b3");
    lvl_i = '0;
    quiet(4, "rr_quiet");

    // Backpressure: offer on 1 stays put while input 0 gets an edge.
    evt_ready = 1'b0;
    lvl_i = 4'b0010;
    cyc(1);
    lvl_i = '0;
    cyc(1);
    check("bp_valid", evt_valid, 1);
    check("bp_id", evt_id, 1);
    lvl_i = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      lvl_i = '0;
      check("bp_hold_valid", evt_valid, 1);
      check("bp_hold_id", evt_id, 1);
    end
    evt_ready = 1'b1;
    wait_hs(1, "bp_first");
    wait_hs(0, "bp_next");
    quiet(4, "bp_quiet");

    // Saturation: five edges on 3, only three survive.
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      lvl_i = 4'b1000;
      cyc(1);
      lvl_i = '0;
      cyc(1);
    end
    check("sat_ovf", ovf, 4'b1000);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    check("sat_ovf_clr", ovf, 0);
    evt_ready = 1'b1;
    wait_hs(3, "sat_ev1");
    wait_hs(3, "sat_ev2");
    wait_hs(3, "sat_ev3");
    quiet(8, "sat_quiet");

    // en gating: pending event on 2 survives, edges on 1 are dropped.
    evt_ready = 1'b0;
    lvl_i = 4'b0100;
    cyc(1);
    lvl_i = '0;
    cyc(3);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lvl_i = 4'b0010;
      cyc(1);
      lvl_i = '0;
      cyc(1);
    end
    evt_ready = 1'b1;
    wait_hs(2, "en_pending");
    quiet(10, "en_dropped");
    en = 1'b1;

    // Reset while offering: pend[0]=2 and ovf[2] set, all cleared.
    evt_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      lvl_i = 4'b0101;
      cyc(1);
      lvl_i = '0;
      cyc(1);
    end
    for (int i = 0; i < 2; i++) begin
      lvl_i = 4'b0100;
      cyc(1);
      lvl_i = '0;
      cyc(1);
    end
    check("mid_valid", evt_valid, 1);
    check("mid_id", evt_id, 0);
    check("mid_ovf", ovf, 4'b0100);
    rst_n = 1'b0;
    evt_ready = 1'b1;
    lvl_i = 4'b1001;
    cyc(1);
    rst_n = 1'b1;
    check("mid_rst_valid", evt_valid, 0);
    check("mid_rst_ovf", ovf, 0);
    // Inputs high at release count as edges; rr_ptr restarts at 0.
    wait_hs(0, "rel_ev0");
    wait_hs(3, "rel_ev3");
    lvl_i = '0;
    quiet(10, "rel_quiet");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
